narrow_wide_bank_mux: RTL and testbench
=======================================

# narrow_wide_bank_mux

Per-bank request multiplexer and response router directly downstream of the memory island's narrow/wide arbiter. It consumes the granted narrow and wide requests, drives one SRAM macro port per narrow-width bank, and tracks each access through a fixed-latency pipeline. It returns read data and write acknowledges to whichever port issued the access. Wide accesses span `NarrowPerWide` adjacent banks and complete as a single wide response.

## Interface
- `NumNarrowBanks`, default 8: number of narrow-width SRAM banks.
- `NumWideBanks`, default 2: wide ports; `NarrowPerWide = NumNarrowBanks / NumWideBanks`.
- `NarrowDataWidth`, default 64: bank word width.
- `WideDataWidth`, default 256: must equal `NarrowPerWide * NarrowDataWidth`.
- `BankAddrWidth`, default 10: row address per bank.
- `BankLatency`, default 1: SRAM read latency in cycles, range 1..4.
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `narrow_valid_i`, input, `[NumNarrowBanks]`: narrow request valid.
- `narrow_ready_i`, input, `[NumNarrowBanks]`: arbiter grant (`q_ready`).
- `narrow_addr_i`, input, `[NumNarrowBanks][BankAddrWidth]`: narrow request row address.
- `narrow_we_i`, input, `[NumNarrowBanks]`: narrow request write enable.
- `narrow_wdata_i`, input, `[NumNarrowBanks][NarrowDataWidth]`: narrow request write data.
- `narrow_be_i`, input, `[NumNarrowBanks][NarrowDataWidth/8]`: narrow request byte enables.
- `wide_valid_i`, `wide_ready_i`, `wide_addr_i`, `wide_we_i`, `wide_wdata_i`, `wide_be_i`: same fields per wide port, with `WideDataWidth` data and `WideDataWidth/8` byte enables.
- `bank_req_o`, output, `[NumNarrowBanks]`: SRAM chip enable.
- `bank_we_o`, output, `[NumNarrowBanks]`: SRAM write enable.
- `bank_addr_o`, output, `[NumNarrowBanks][BankAddrWidth]`: SRAM row address.
- `bank_wdata_o`, output, `[NumNarrowBanks][NarrowDataWidth]`: SRAM write data.
- `bank_be_o`, output, `[NumNarrowBanks][NarrowDataWidth/8]`: SRAM byte enables.
- `bank_rdata_i`, input, `[NumNarrowBanks][NarrowDataWidth]`: SRAM read data.
- `narrow_rvalid_o`, output, `[NumNarrowBanks]`: narrow response valid.
- `narrow_rdata_o`, output, `[NumNarrowBanks][NarrowDataWidth]`: narrow response data.
- `wide_rvalid_o`, output, `[NumWideBanks]`: wide response valid.
- `wide_rdata_o`, output, `[NumWideBanks][WideDataWidth]`: wide response data.
- `conflict_o`, output, 1: sticky error flag.

## Operation
- Grant per bank `i`, with `j = i / NarrowPerWide` and `k = i % NarrowPerWide`:
  - `ng = narrow_valid_i[i] & narrow_ready_i[i]`.
  - `wg = wide_valid_i[j] & wide_ready_i[j]`.
- Bank drive:
  - `ng`: narrow fields pass through unchanged.
  - `wg` only: addr = `wide_addr_i[j]`; wdata and be = slice `k`, i.e. bits `[k*NarrowDataWidth +: NarrowDataWidth]`.
  - Neither: `bank_req_o = 0`; other bank outputs are don't-care but driven to 0.
- Conflict: `ng & wg` on the same bank in the same cycle.
  - Narrow wins.
  - The wide access is dropped on every bank of group `j`.
  - `conflict_o` sets to 1 and holds until reset.
- Tracking: each bank has a `BankLatency`-deep shift register of `{valid, is_wide}`.
  - Entry pushed every cycle: `{ng | (wg & ~conflict_j), ~ng & wg}`.
- Responses are generated for reads and writes alike.
  - Write response = acknowledge; its rdata is 0 (masked).
- Narrow response: `narrow_rvalid_o[i]` = tracker-out valid & ~is_wide; rdata = `bank_rdata_i[i]`.
- Wide response: `wide_rvalid_o[j]` = AND over the group's tracker-out `valid & is_wide`; rdata = concatenation of the group's `bank_rdata_i`, slice `k` at bits `k*NarrowDataWidth`.
- No backpressure on responses; consumers always accept.

## Timing
- Bank request outputs are combinational from the inputs: zero-cycle request path.
- Response is asserted exactly `BankLatency` cycles after the grant cycle, for one cycle.
- Back-to-back grants produce back-to-back responses; throughput is 1 access per bank per cycle.
- Reset values: all tracker entries 0, all `*_rvalid_o` 0, `conflict_o` 0.
- Reset mid-operation clears the trackers; in-flight responses are dropped and never reappear after reset.
- A wide access in a group is never split: either all `NarrowPerWide` banks issue it or none do.

## Structure
- `lagd_mem_pkg` holds:
  - the `NarrowPerWide` computation function;
  - the tracker entry typedef `{valid, is_wide}`;
  - the `BankLatency` bounds.
- Sub-module `bank_rsp_tracker`: one per narrow bank; parameterised shift register for `{valid, is_wide}`.
- Static asserts:
  - `WideDataWidth == NarrowPerWide * NarrowDataWidth`.
  - `NumNarrowBanks % NumWideBanks == 0`.
  - `BankLatency` in 1..4.

## Test plan
- Narrow read, bank 3, addr 0x12, `BankLatency = 2`, SRAM returns 0xA5 -> `bank_req_o[3] = 1` in cycle 0; `narrow_rvalid_o[3] = 1` with rdata 0xA5 in cycle 2 only.
- Wide write, port 1, be all-ones -> banks 4..7 are written in the same cycle, each with its 64-bit slice; `wide_rvalid_o[1]` pulses once after `BankLatency`.
- Wide read, port 0, banks return 0x0,0x1,0x2,0x3 -> `wide_rdata_o[0] = {3,2,1,0}` at 64-bit slices; no `narrow_rvalid_o` asserted.
- Forced conflict: narrow and wide both granted on bank 1 -> narrow is serviced; banks 0..3 do not issue the wide access; `conflict_o` rises and stays 1.
- Continuous alternating narrow/wide grants for 100 cycles -> every grant gets exactly one response with correct data and order.
- `rst_ni` asserted with 3 accesses in flight -> no `*_rvalid_o` asserted after release until new grants.

Source files
------------

// File: rtl/lagd_mem_pkg.sv
// Shared types and helpers for the memory island bank datapath.
package lagd_mem_pkg;

  localparam int unsigned MinBankLatency = 1;
  localparam int unsigned MaxBankLatency = 4;

  typedef struct packed {
    logic valid;
    logic is_wide;
  } rsp_entry_t;

  function automatic int unsigned calc_narrow_per_wide(int unsigned num_narrow,
                                                       int unsigned num_wide);
    return num_narrow / num_wide;
  endfunction

endpackage

// File: rtl/bank_rsp_tracker.sv
// Fixed-latency shift register that follows one bank's accesses to their response slot.
module bank_rsp_tracker
  import lagd_mem_pkg::*;
#(
  parameter int unsigned Latency = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  rsp_entry_t entry_i,
  input  logic       write_i,
  output rsp_entry_t entry_o,
  output logic       write_o
);

  rsp_entry_t [Latency-1:0] entry_q;
  logic       [Latency-1:0] write_q;

  // The write flag rides alongside the entry so write acks can mask read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
      write_q <= '0;
    end else begin
      entry_q[0] <= entry_i;
      write_q[0] <= write_i;
      for (int s = 1; s < int'(Latency); s++) begin
        entry_q[s] <= entry_q[s-1];
        write_q[s] <= write_q[s-1];
      end
    end
  end

  assign entry_o = entry_q[Latency-1];
  assign write_o = write_q[Latency-1];

endmodule

// File: rtl/narrow_wide_bank_mux.sv
// Per-bank narrow/wide request mux with fixed-latency response routing.
module narrow_wide_bank_mux
  import lagd_mem_pkg::*;
#(
  parameter int unsigned NumNarrowBanks  = 8,
  parameter int unsigned NumWideBanks    = 2,
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned WideDataWidth   = 256,
  parameter int unsigned BankAddrWidth   = 10,
  parameter int unsigned BankLatency     = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [NumNarrowBanks-1:0]                        narrow_valid_i,
  input  logic [NumNarrowBanks-1:0]                        narrow_ready_i,
  input  logic [NumNarrowBanks-1:0][BankAddrWidth-1:0]     narrow_addr_i,
  input  logic [NumNarrowBanks-1:0]                        narrow_we_i,
  input  logic [NumNarrowBanks-1:0][NarrowDataWidth-1:0]   narrow_wdata_i,
  input  logic [NumNarrowBanks-1:0][NarrowDataWidth/8-1:0] narrow_be_i,
  input  logic [NumWideBanks-1:0]                          wide_valid_i,
  input  logic [NumWideBanks-1:0]                          wide_ready_i,
  input  logic [NumWideBanks-1:0][BankAddrWidth-1:0]       wide_addr_i,
  input  logic [NumWideBanks-1:0]                          wide_we_i,
  input  logic [NumWideBanks-1:0][WideDataWidth-1:0]       wide_wdata_i,
  input  logic [NumWideBanks-1:0][WideDataWidth/8-1:0]     wide_be_i,
  output logic [NumNarrowBanks-1:0]                        bank_req_o,
  output logic [NumNarrowBanks-1:0]                        bank_we_o,
  output logic [NumNarrowBanks-1:0][BankAddrWidth-1:0]     bank_addr_o,
  output logic [NumNarrowBanks-1:0][NarrowDataWidth-1:0]   bank_wdata_o,
  output logic [NumNarrowBanks-1:0][NarrowDataWidth/8-1:0] bank_be_o,
  input  logic [NumNarrowBanks-1:0][NarrowDataWidth-1:0]   bank_rdata_i,
  output logic [NumNarrowBanks-1:0]                        narrow_rvalid_o,
  output logic [NumNarrowBanks-1:0][NarrowDataWidth-1:0]   narrow_rdata_o,
  output logic [NumWideBanks-1:0]                          wide_rvalid_o,
  output logic [NumWideBanks-1:0][WideDataWidth-1:0]       wide_rdata_o,
  output logic                                             conflict_o
);

  localparam int unsigned NarrowPerWide = calc_narrow_per_wide(NumNarrowBanks, NumWideBanks);
  localparam int unsigned NarrowBeWidth = NarrowDataWidth / 8;

  if (WideDataWidth != NarrowPerWide * NarrowDataWidth) begin : g_err_width
    $error("WideDataWidth must equal NarrowPerWide * NarrowDataWidth");
  end
  if (NumNarrowBanks % NumWideBanks != 0) begin : g_err_banks
    $error("NumNarrowBanks must be a multiple of NumWideBanks");
  end
  if (BankLatency < MinBankLatency || BankLatency > MaxBankLatency) begin : g_err_lat
    $error("BankLatency out of range");
  end

  logic       [NumNarrowBanks-1:0] ng;
  logic       [NumWideBanks-1:0]   wide_gnt;
  logic       [NumWideBanks-1:0]   grp_conflict;
  logic       [NumNarrowBanks-1:0] grp_done;
  logic       [NumNarrowBanks-1:0] rsp_write;
  rsp_entry_t [NumNarrowBanks-1:0] push_entry;
  rsp_entry_t [NumNarrowBanks-1:0] rsp_entry;
  logic                            conflict_q;

  assign ng       = narrow_valid_i & narrow_ready_i;
  assign wide_gnt = wide_valid_i & wide_ready_i;

  for (genvar i = 0; i < NumNarrowBanks; i++) begin : g_bank
    localparam int unsigned J = i / NarrowPerWide;
    localparam int unsigned K = i % NarrowPerWide;
    logic wide_go;

    // A wide access survives only if no bank of its group took a narrow grant.
    assign wide_go = wide_gnt[J] & ~grp_conflict[J];

    assign bank_req_o[i]   = ng[i] | wide_go;
    assign bank_we_o[i]    = ng[i] ? narrow_we_i[i] : (wide_go & wide_we_i[J]);
    assign bank_addr_o[i]  = ng[i] ? narrow_addr_i[i] :
                             wide_go ? wide_addr_i[J] : '0;
    assign bank_wdata_o[i] = ng[i] ? narrow_wdata_i[i] :
                             wide_go ? wide_wdata_i[J][K*NarrowDataWidth +: NarrowDataWidth] : '0;
    assign bank_be_o[i]    = ng[i] ? narrow_be_i[i] :
                             wide_go ? wide_be_i[J][K*NarrowBeWidth +: NarrowBeWidth] : '0;

    assign push_entry[i] = '{valid: ng[i] | wide_go, is_wide: ~ng[i] & wide_gnt[J]};

    bank_rsp_tracker #(
      .Latency (BankLatency)
    ) i_tracker (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .entry_i (push_entry[i]),
      .write_i (bank_we_o[i]),
      .entry_o (rsp_entry[i]),
      .write_o (rsp_write[i])
    );

    assign narrow_rvalid_o[i] = rsp_entry[i].valid & ~rsp_entry[i].is_wide;
    assign narrow_rdata_o[i]  = (narrow_rvalid_o[i] & ~rsp_write[i]) ? bank_rdata_i[i] : '0;
    assign grp_done[i]        = rsp_entry[i].valid & rsp_entry[i].is_wide;
  end

  for (genvar j = 0; j < NumWideBanks; j++) begin : g_wide
    assign grp_conflict[j]  = wide_gnt[j] & (|ng[j*NarrowPerWide +: NarrowPerWide]);
    assign wide_rvalid_o[j] = &grp_done[j*NarrowPerWide +: NarrowPerWide];
    assign wide_rdata_o[j]  = (wide_rvalid_o[j] & ~rsp_write[j*NarrowPerWide]) ?
                              bank_rdata_i[j*NarrowPerWide +: NarrowPerWide] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= 1'b0;
    end else if (|grp_conflict) begin
      conflict_q <= 1'b1;
    end
  end

  assign conflict_o = conflict_q;

endmodule

// File: tb/tb_narrow_wide_bank_mux.sv
// Self-checking bench: request-path vector table, directed response sequences, randomized model run.
module tb_narrow_wide_bank_mux;

  localparam int NB = 8, NW = 2, NPW = 4, NDW = 64, WDW = 256, AW = 10, LAT = 2;
  localparam int NBE = NDW / 8, WBE = WDW / 8;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [NB-1:0]          narrow_valid_i, narrow_ready_i, narrow_we_i;
  logic [NB-1:0][AW-1:0]  narrow_addr_i;
  logic [NB-1:0][NDW-1:0] narrow_wdata_i;
  logic [NB-1:0][NBE-1:0] narrow_be_i;
  logic [NW-1:0]          wide_valid_i, wide_ready_i, wide_we_i;
  logic [NW-1:0][AW-1:0]  wide_addr_i;
  logic [NW-1:0][WDW-1:0] wide_wdata_i;
  logic [NW-1:0][WBE-1:0] wide_be_i;
  logic [NB-1:0]          bank_req_o, bank_we_o;
  logic [NB-1:0][AW-1:0]  bank_addr_o;
  logic [NB-1:0][NDW-1:0] bank_wdata_o;
  logic [NB-1:0][NBE-1:0] bank_be_o;
  logic [NB-1:0][NDW-1:0] bank_rdata_i;
  logic [NB-1:0]          narrow_rvalid_o;
  logic [NB-1:0][NDW-1:0] narrow_rdata_o;
  logic [NW-1:0]          wide_rvalid_o;
  logic [NW-1:0][WDW-1:0] wide_rdata_o;
  logic                   conflict_o;

  narrow_wide_bank_mux #(
    .NumNarrowBanks(NB), .NumWideBanks(NW), .NarrowDataWidth(NDW),
    .WideDataWidth(WDW), .BankAddrWidth(AW), .BankLatency(LAT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .narrow_valid_i(narrow_valid_i), .narrow_ready_i(narrow_ready_i),
    .narrow_addr_i(narrow_addr_i), .narrow_we_i(narrow_we_i),
    .narrow_wdata_i(narrow_wdata_i), .narrow_be_i(narrow_be_i),
    .wide_valid_i(wide_valid_i), .wide_ready_i(wide_ready_i),
    .wide_addr_i(wide_addr_i), .wide_we_i(wide_we_i),
    .wide_wdata_i(wide_wdata_i), .wide_be_i(wide_be_i),
    .bank_req_o(bank_req_o), .bank_we_o(bank_we_o), .bank_addr_o(bank_addr_o),
    .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o), .bank_rdata_i(bank_rdata_i),
    .narrow_rvalid_o(narrow_rvalid_o), .narrow_rdata_o(narrow_rdata_o),
    .wide_rvalid_o(wide_rvalid_o), .wide_rdata_o(wide_rdata_o),
    .conflict_o(conflict_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected responses, indexed by due cycle modulo 8.
  bit exp_nv [8][NB];
  bit exp_nw [8][NB];
  bit exp_wv [8][NW];
  bit exp_ww [8][NW];
  bit exp_conf;

  typedef struct {
    logic [NB-1:0] nv;
    logic [NB-1:0] nr;
    logic [NW-1:0] wv;
    logic [NW-1:0] wr;
    logic [NB-1:0] exp_req;
  } vec_t;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [NDW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < NB; i++) begin exp_nv[s][i] = 0; exp_nw[s][i] = 0; end
      for (int j = 0; j < NW; j++) begin exp_wv[s][j] = 0; exp_ww[s][j] = 0; end
    end
  endtask

  task automatic idle();
    narrow_valid_i = '0; narrow_ready_i = '0; narrow_we_i = '0;
    wide_valid_i = '0; wide_ready_i = '0; wide_we_i = '0;
    for (int i = 0; i < NB; i++) begin
      narrow_addr_i[i] = AW'($urandom); narrow_wdata_i[i] = rnd64();
      narrow_be_i[i] = NBE'($urandom); bank_rdata_i[i] = rnd64();
    end
    for (int j = 0; j < NW; j++) begin
      wide_addr_i[j] = AW'($urandom); wide_be_i[j] = $urandom;
      for (int k = 0; k < NPW; k++) wide_wdata_i[j][k*NDW +: NDW] = rnd64();
    end
  endtask

  task automatic drive_narrow_rand();
    idle();
    for (int i = 0; i < NB; i++) begin
      narrow_valid_i[i] = ($urandom_range(0, 3) != 0);
      narrow_ready_i[i] = ($urandom_range(0, 3) != 0);
      narrow_we_i[i]    = $urandom_range(0, 1);
    end
  endtask

  task automatic drive_wide_rand(bit keep_narrow);
    if (!keep_narrow) idle();
    for (int j = 0; j < NW; j++) begin
      wide_valid_i[j] = ($urandom_range(0, 3) != 0);
      wide_ready_i[j] = ($urandom_range(0, 3) != 0);
      wide_we_i[j]    = $urandom_range(0, 1);
    end
  endtask

  // Check this cycle against the model, then advance to the next negedge.
  task automatic tick();
    int s, d, nn;
    bit conflict_now;
    bit wacc [NW];
    logic e_req, e_we;
    logic [AW-1:0] e_a;
    logic [NBE-1:0] e_be;
    logic [NDW-1:0] e_wd;
    logic [WDW-1:0] e_wr;
    #1;
    s = cyc % 8;
    d = (cyc + LAT) % 8;
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("narrow_rvalid[%0d] cyc %0d", i, cyc), narrow_rvalid_o[i], exp_nv[s][i]);
      if (exp_nv[s][i])
        chk($sformatf("narrow_rdata[%0d] cyc %0d", i, cyc), narrow_rdata_o[i],
            exp_nw[s][i] ? '0 : bank_rdata_i[i]);
      exp_nv[s][i] = 0; exp_nw[s][i] = 0;
    end
    for (int j = 0; j < NW; j++) begin
      chk($sformatf("wide_rvalid[%0d] cyc %0d", j, cyc), wide_rvalid_o[j], exp_wv[s][j]);
      if (exp_wv[s][j]) begin
        e_wr = '0;
        if (!exp_ww[s][j])
          for (int k = 0; k < NPW; k++) e_wr[k*NDW +: NDW] = bank_rdata_i[j*NPW + k];
        chk($sformatf("wide_rdata[%0d] cyc %0d", j, cyc), wide_rdata_o[j], e_wr);
      end
      exp_wv[s][j] = 0; exp_ww[s][j] = 0;
    end
    conflict_now = 0;
    for (int j = 0; j < NW; j++) begin
      nn = 0;
      for (int k = 0; k < NPW; k++)
        if (narrow_valid_i[j*NPW + k] && narrow_ready_i[j*NPW + k]) nn++;
      wacc[j] = wide_valid_i[j] && wide_ready_i[j] && (nn == 0);
      if (wide_valid_i[j] && wide_ready_i[j] && nn > 0) conflict_now = 1;
      if (wacc[j]) begin exp_wv[d][j] = 1; exp_ww[d][j] = wide_we_i[j]; end
    end
    for (int i = 0; i < NB; i++) begin
      int j, k;
      j = i / NPW; k = i % NPW;
      e_req = 0; e_we = 0; e_a = '0; e_be = '0; e_wd = '0;
      if (narrow_valid_i[i] && narrow_ready_i[i]) begin
        e_req = 1; e_we = narrow_we_i[i]; e_a = narrow_addr_i[i];
        e_be = narrow_be_i[i]; e_wd = narrow_wdata_i[i];
        exp_nv[d][i] = 1; exp_nw[d][i] = narrow_we_i[i];
      end else if (wacc[j]) begin
        e_req = 1; e_we = wide_we_i[j]; e_a = wide_addr_i[j];
        e_be = wide_be_i[j][k*NBE +: NBE]; e_wd = wide_wdata_i[j][k*NDW +: NDW];
      end
      chk($sformatf("bank[%0d] drive cyc %0d", i, cyc),
          {bank_req_o[i], bank_we_o[i], bank_addr_o[i], bank_be_o[i], bank_wdata_o[i]},
          {e_req, e_we, e_a, e_be, e_wd});
    end
    chk($sformatf("conflict cyc %0d", cyc), conflict_o, exp_conf);
    if (conflict_now) exp_conf = 1;
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    idle();
    #2 rst_ni = 1'b0;
    clear_model();
    exp_conf = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    logic [WDW-1:0] wd;
    logic [WDW-1:0] exp_wide;

    vecs[0] = '{nv: 8'h08, nr: 8'h08, wv: 2'b00, wr: 2'b00, exp_req: 8'h08};
    vecs[1] = '{nv: 8'h08, nr: 8'h00, wv: 2'b00, wr: 2'b00, exp_req: 8'h00};
    vecs[2] = '{nv: 8'h00, nr: 8'h00, wv: 2'b10, wr: 2'b10, exp_req: 8'hF0};
    vecs[3] = '{nv: 8'h00, nr: 8'hFF, wv: 2'b01, wr: 2'b01, exp_req: 8'h0F};
    vecs[4] = '{nv: 8'h00, nr: 8'h00, wv: 2'b11, wr: 2'b11, exp_req: 8'hFF};
    vecs[5] = '{nv: 8'h00, nr: 8'h00, wv: 2'b11, wr: 2'b01, exp_req: 8'h0F};
    vecs[6] = '{nv: 8'h81, nr: 8'h81, wv: 2'b00, wr: 2'b00, exp_req: 8'h81};
    vecs[7] = '{nv: 8'hFF, nr: 8'h0F, wv: 2'b10, wr: 2'b10, exp_req: 8'hFF};
    vecs[8] = '{nv: 8'h02, nr: 8'h02, wv: 2'b01, wr: 2'b01, exp_req: 8'h02};
    vecs[9] = '{nv: 8'h02, nr: 8'h02, wv: 2'b11, wr: 2'b11, exp_req: 8'hF2};

    idle();
    clear_model();
    exp_conf = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("reset narrow_rvalid", narrow_rvalid_o, 0);
    chk("reset wide_rvalid", wide_rvalid_o, 0);
    chk("reset conflict", conflict_o, 0);
    @(negedge clk_i);

    // Request-path vector table
    for (int v = 0; v < 10; v++) begin
      idle();
      narrow_valid_i = vecs[v].nv; narrow_ready_i = vecs[v].nr;
      wide_valid_i = vecs[v].wv; wide_ready_i = vecs[v].wr;
      narrow_we_i = NB'($urandom); wide_we_i = NW'($urandom);
      #1;
      chk($sformatf("vec%0d bank_req", v), bank_req_o, vecs[v].exp_req);
      tick();
    end
    repeat (3) begin idle(); tick(); end

    // Narrow read on bank 3, response two cycles later only
    do_reset();
    idle();
    narrow_valid_i[3] = 1; narrow_ready_i[3] = 1; narrow_addr_i[3] = 10'h12;
    #1;
    chk("nread req3", bank_req_o[3], 1);
    chk("nread addr3", bank_addr_o[3], 10'h12);
    tick();
    idle(); #1; chk("nread early rvalid3", narrow_rvalid_o[3], 0); tick();
    idle(); bank_rdata_i[3] = 64'hA5; #1;
    chk("nread rvalid3", narrow_rvalid_o[3], 1);
    chk("nread rdata3", narrow_rdata_o[3], 64'hA5);
    tick();
    idle(); #1; chk("nread late rvalid3", narrow_rvalid_o[3], 0); tick();

    // Wide write on port 1
    idle();
    wide_valid_i[1] = 1; wide_ready_i[1] = 1; wide_we_i[1] = 1; wide_be_i[1] = '1;
    wd = wide_wdata_i[1];
    #1;
    for (int k = 0; k < NPW; k++) begin
      chk($sformatf("wwrite bank%0d req/we/be", 4 + k),
          {bank_req_o[4+k], bank_we_o[4+k], bank_be_o[4+k]}, {2'b11, 8'hFF});
      chk($sformatf("wwrite bank%0d wdata", 4 + k), bank_wdata_o[4+k], wd[k*NDW +: NDW]);
    end
    chk("wwrite banks0-3 idle", bank_req_o[3:0], 0);
    tick();
    idle(); #1; chk("wwrite early rvalid1", wide_rvalid_o[1], 0); tick();
    idle(); #1; chk("wwrite rvalid1", wide_rvalid_o[1], 1); tick();
    idle(); #1; chk("wwrite late rvalid1", wide_rvalid_o[1], 0); tick();

    // Wide read on port 0 assembles four bank words
    idle();
    wide_valid_i[0] = 1; wide_ready_i[0] = 1;
    tick();
    idle(); tick();
    idle();
    for (int k = 0; k < NPW; k++) bank_rdata_i[k] = NDW'(k);
    exp_wide = {64'd3, 64'd2, 64'd1, 64'd0};
    #1;
    chk("wread rvalid0", wide_rvalid_o[0], 1);
    chk("wread rdata0", wide_rdata_o[0], exp_wide);
    chk("wread no narrow rvalid", narrow_rvalid_o, 0);
    tick();

    // Forced conflict on bank 1
    idle();
    narrow_valid_i[1] = 1; narrow_ready_i[1] = 1;
    wide_valid_i[0] = 1; wide_ready_i[0] = 1;
    #1;
    chk("conflict bank_req", bank_req_o, 8'h02);
    chk("conflict before edge", conflict_o, 0);
    tick();
    idle(); #1; chk("conflict raised", conflict_o, 1); tick();
    repeat (3) begin idle(); tick(); end
    #1; chk("conflict sticky", conflict_o, 1);

    // Reset with three accesses in flight
    idle();
    narrow_valid_i[0] = 1; narrow_ready_i[0] = 1;
    narrow_valid_i[1] = 1; narrow_ready_i[1] = 1; narrow_we_i[1] = 1;
    wide_valid_i[1] = 1; wide_ready_i[1] = 1;
    tick();
    do_reset();
    #1; chk("post-reset conflict", conflict_o, 0);
    for (int n = 0; n < 4; n++) begin
      idle(); #1;
      chk($sformatf("post-reset rvalid %0d", n), {narrow_rvalid_o, wide_rvalid_o}, 0);
      tick();
    end

    // Alternating narrow/wide traffic, then fully mixed traffic
    for (int n = 0; n < 100; n++) begin
      if (n % 2 == 0) drive_narrow_rand();
      else drive_wide_rand(0);
      tick();
    end
    for (int n = 0; n < 100; n++) begin
      drive_narrow_rand();
      if ($urandom_range(0, 1) != 0) begin
        narrow_valid_i = narrow_valid_i & NB'($urandom);
        drive_wide_rand(1);
      end
      tick();
    end
    repeat (LAT + 1) begin idle(); tick(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
